// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-16 core and its instruction-memory loader:
// default widths, the loader state encoding and a state decode helper.
package mips_pkg;

    localparam int DEFAULT_INST_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    // Loader FSM encoding, kept as plain constants so older blocks can share it.
    typedef logic [2:0] loaderState_t;

    localparam loaderState_t IDLE    = 3'd0;
    localparam loaderState_t LEN_LO  = 3'd1;
    localparam loaderState_t LEN_HI  = 3'd2;
    localparam loaderState_t DATA_LO = 3'd3;
    localparam loaderState_t DATA_HI = 3'd4;
    localparam loaderState_t FINISH  = 3'd5;

    // States in which the loader is consuming stream bytes.
    function automatic logic stateAcceptsBytes(input loaderState_t state);
        return (state == LEN_LO) || (state == LEN_HI) ||
               (state == DATA_LO) || (state == DATA_HI);
    endfunction

endpackage

// File: rtl/byte_pair_assembler.sv
// Pairs consecutive stream bytes (LO first, then HI) into one 16-bit word.
// The word and its wordValid pulse are presented in the same cycle as the HI
// byte transfer; the owner registers them.
module byte_pair_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byteFire,
    input  logic [7:0]  byteIn,
    output logic [15:0] word,
    output logic        wordValid
);

    logic [7:0] loByte;
    logic       hiPhase;

    // Track the LO/HI phase and hold the LO byte until its partner arrives.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loByte  <= '0;
            hiPhase <= 1'b0;
        end else if (clear) begin
            hiPhase <= 1'b0;
        end else if (byteFire) begin
            if (!hiPhase) begin
                loByte <= byteIn;
            end
            hiPhase <= ~hiPhase;
        end
    end

    assign word      = {byteIn, loByte};
    assign wordValid = byteFire & hiPhase;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: consumes a length-prefixed byte stream, writes
// each assembled instruction to consecutive addresses and stalls the core
// while a load is in progress. At integration, coreHold is ORed into the
// global stall and memWriteEn selects this block onto the IF write port.
module imem_loader
    import mips_pkg::*;
#(
    parameter int INST_WIDTH = DEFAULT_INST_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    output logic                  memWriteEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [INST_WIDTH-1:0] memWriteData,
    output logic                  coreHold,
    output logic                  done,
    output logic                  overflow
);

    // Memory depth in 17 bits so a 16-bit length can be compared without wrap.
    localparam logic [16:0] MEM_DEPTH = 17'(1) << ADDR_WIDTH;

    loaderState_t state;
    logic [7:0]   lenLo;
    logic [15:0]  wordCount;
    logic [15:0]  counter;

    logic         byteFire;
    logic [15:0]  lenWord;
    logic         lenExceedsDepth;
    logic         inRange;
    logic         lastWord;
    logic [15:0]  word;
    logic         wordValid;

    assign byteReady       = stateAcceptsBytes(state);
    assign byteFire        = byteValid & byteReady;
    assign lenWord         = {byteIn, lenLo};
    assign lenExceedsDepth = {1'b0, lenWord} > MEM_DEPTH;
    assign inRange         = {1'b0, counter} < MEM_DEPTH;
    assign lastWord        = ({1'b0, counter} + 17'd1) == {1'b0, wordCount};

    // The phase restarts at the header so every data run begins on a LO byte.
    byte_pair_assembler u_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == LEN_HI),
        .byteFire  (byteFire && (state == DATA_LO || state == DATA_HI)),
        .byteIn    (byteIn),
        .word      (word),
        .wordValid (wordValid)
    );

    // Loader FSM with registered memory-port, hold, done and overflow outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lenLo        <= '0;
            wordCount    <= '0;
            counter      <= '0;
            memWriteEn   <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
            coreHold     <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            memWriteEn <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= LEN_LO;
                        coreHold <= 1'b1;
                        overflow <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (byteFire) begin
                        lenLo <= byteIn;
                        state <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (byteFire) begin
                        wordCount <= lenWord;
                        counter   <= '0;
                        if (lenWord == 16'd0) begin
                            state    <= FINISH;
                            done     <= 1'b1;
                            coreHold <= 1'b0;
                        end else begin
                            state   <= DATA_LO;
                            memAddr <= '0;
                        end
                        if (lenExceedsDepth) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                DATA_LO: begin
                    if (byteFire) begin
                        state <= DATA_HI;
                    end
                end
                DATA_HI: begin
                    if (wordValid) begin
                        // Words past the end of memory are drained, never written.
                        if (inRange) begin
                            memWriteEn   <= 1'b1;
                            memAddr      <= counter[ADDR_WIDTH-1:0];
                            memWriteData <= INST_WIDTH'(word);
                        end
                        counter <= counter + 16'd1;
                        if (lastWord) begin
                            state    <= FINISH;
                            done     <= 1'b1;
                            coreHold <= 1'b0;
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Two instances share the byte stream: one at
// the default depth and one with ADDR_WIDTH=2 for the overflow case. The idle
// instance never sees a load, so it ignores the stream.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load8 = 1'b0;
    logic       load2 = 1'b0;
    logic [7:0] byteIn = 8'h00;
    logic       byteValid = 1'b0;
    bit         sel2 = 1'b0;

    logic        ready8, we8, hold8, done8, ovf8;
    logic [7:0]  addr8;
    logic [15:0] data8;
    logic        ready2, we2, hold2, done2, ovf2;
    logic [1:0]  addr2;
    logic [15:0] data2;

    logic        obsReady, obsWe, obsHold, obsDone, obsOvf;
    logic [7:0]  obsAddr;
    logic [15:0] obsData;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;

    int wrAddr[$];
    int wrData[$];
    int wrCyc[$];
    int doneCyc[$];
    int xferCyc[$];
    bit holdSeen;
    logic [7:0] stim[$];
    int expAddr[$];
    int expData[$];

    imem_loader #(.INST_WIDTH(16), .ADDR_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .load(load8), .byteIn(byteIn),
        .byteValid(byteValid), .byteReady(ready8), .memWriteEn(we8),
        .memAddr(addr8), .memWriteData(data8), .coreHold(hold8),
        .done(done8), .overflow(ovf8)
    );

    imem_loader #(.INST_WIDTH(16), .ADDR_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .load(load2), .byteIn(byteIn),
        .byteValid(byteValid), .byteReady(ready2), .memWriteEn(we2),
        .memAddr(addr2), .memWriteData(data2), .coreHold(hold2),
        .done(done2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        if (sel2) begin
            obsReady = ready2; obsWe = we2; obsHold = hold2; obsDone = done2;
            obsOvf = ovf2; obsAddr = {6'b0, addr2}; obsData = data2;
        end else begin
            obsReady = ready8; obsWe = we8; obsHold = hold8; obsDone = done8;
            obsOvf = ovf8; obsAddr = addr8; obsData = data8;
        end
    end

    // Log every write and done pulse with the number of rising edges so far.
    always @(negedge clk) begin
        if (obsWe) begin
            wrAddr.push_back(int'(obsAddr));
            wrData.push_back(int'(obsData));
            wrCyc.push_back(cyc);
        end
        if (obsDone) doneCyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearLog();
        wrAddr.delete(); wrData.delete(); wrCyc.delete();
        doneCyc.delete(); xferCyc.delete();
        holdSeen = 1'b1;
    endtask

    task automatic startLoad();
        if (sel2) load2 = 1'b1; else load8 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        load8 = 1'b0;
    endtask

    // Present one byte; it transfers at the next rising edge once byteReady is high.
    task automatic sendByte(input logic [7:0] b, input bit gap);
        int waits = 0;
        if (gap) begin
            byteValid = 1'b0;
            @(negedge clk);
        end
        byteIn = b;
        byteValid = 1'b1;
        while (!obsReady && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("byte_ready", obsReady, 1);
        xferCyc.push_back(cyc);
        holdSeen &= obsHold;
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic sendStream(input logic [7:0] bytes[$], input bit gap);
        foreach (bytes[i]) sendByte(bytes[i], gap);
    endtask

    task automatic expectWrites(input string tag);
        check({tag, "_count"}, wrAddr.size(), expAddr.size());
        for (int i = 0; i < expAddr.size() && i < wrAddr.size(); i++) begin
            check({tag, "_addr"}, wrAddr[i], expAddr[i]);
            check({tag, "_data"}, wrData[i], expData[i]);
        end
    endtask

    // Basic stream 02 00 34 12 78 56, optionally with a gap before each byte.
    task automatic basicLoad(input string tag, input bit gap);
        clearLog();
        startLoad();
        check({tag, "_hold_rise"}, obsHold, 1);
        stim = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        sendStream(stim, gap);
        check({tag, "_last_we"}, obsWe, 1);
        check({tag, "_done"}, obsDone, 1);
        check({tag, "_hold_fall"}, obsHold, 0);
        repeat (3) @(negedge clk);
        check({tag, "_hold_during"}, holdSeen, 1);
        expAddr = {0, 1};
        expData = {32'h1234, 32'h5678};
        expectWrites(tag);
        if (wrCyc.size() == 2 && xferCyc.size() == 6) begin
            check({tag, "_lat0"}, wrCyc[0], xferCyc[3] + 1);
            check({tag, "_lat1"}, wrCyc[1], xferCyc[5] + 1);
        end else begin
            check({tag, "_log_sizes"}, {wrCyc.size(), xferCyc.size()}, {2, 6});
        end
        check({tag, "_done_count"}, doneCyc.size(), 1);
        if (doneCyc.size() == 1 && wrCyc.size() == 2)
            check({tag, "_done_with_write"}, doneCyc[0], wrCyc[1]);
        check({tag, "_ovf"}, obsOvf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        holdSeen = 1'b1;
        // Reset values, sampled while reset is held.
        repeat (2) @(negedge clk);
        check("rst_ready", obsReady, 0);
        check("rst_we", obsWe, 0);
        check("rst_addr", obsAddr, 0);
        check("rst_data", obsData, 0);
        check("rst_hold", obsHold, 0);
        check("rst_done", obsDone, 0);
        check("rst_ovf", obsOvf, 0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back stream, then the same stream with byteValid toggling.
        basicLoad("basic", 1'b0);
        basicLoad("gaps", 1'b1);

        // Zero length: done and hold fall right after the LEN_HI transfer.
        clearLog();
        startLoad();
        stim = {8'h00, 8'h00};
        sendStream(stim, 1'b0);
        check("zero_done", obsDone, 1);
        check("zero_hold", obsHold, 0);
        check("zero_ovf", obsOvf, 0);
        repeat (3) @(negedge clk);
        check("zero_writes", wrAddr.size(), 0);
        if (doneCyc.size() == 1 && xferCyc.size() == 2)
            check("zero_done_cyc", doneCyc[0], xferCyc[1] + 1);
        else
            check("zero_done_count", doneCyc.size(), 1);

        // Depth-4 instance: N=4 fits exactly, N=6 overflows.
        sel2 = 1'b1;
        @(negedge clk);
        clearLog();
        startLoad();
        stim = {8'h04, 8'h00};
        sendStream(stim, 1'b0);
        check("fit_ovf", obsOvf, 0);
        stim = {8'h10, 8'hC0, 8'h11, 8'hC1, 8'h12, 8'hC2, 8'h13, 8'hC3};
        sendStream(stim, 1'b0);
        repeat (3) @(negedge clk);
        expAddr = {0, 1, 2, 3};
        expData = {32'hC010, 32'hC111, 32'hC212, 32'hC313};
        expectWrites("fit");

        clearLog();
        startLoad();
        stim = {8'h06, 8'h00};
        sendStream(stim, 1'b0);
        check("ovf_after_len", obsOvf, 1);
        stim = {8'h10, 8'hC0, 8'h11, 8'hC1, 8'h12, 8'hC2,
                8'h13, 8'hC3, 8'h14, 8'hC4, 8'h15, 8'hC5};
        sendStream(stim, 1'b0);
        check("ovf_done", obsDone, 1);
        check("ovf_last_we", obsWe, 0);
        repeat (3) @(negedge clk);
        expectWrites("ovf");
        check("ovf_sticky", obsOvf, 1);
        if (doneCyc.size() == 1 && xferCyc.size() == 14)
            check("ovf_done_cyc", doneCyc[0], xferCyc[13] + 1);
        else
            check("ovf_done_count", doneCyc.size(), 1);
        // A new load clears the flag; finish it with an empty stream.
        clearLog();
        startLoad();
        check("ovf_cleared", obsOvf, 0);
        stim = {8'h00, 8'h00};
        sendStream(stim, 1'b0);
        sel2 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset right after the first word is written.
        clearLog();
        startLoad();
        stim = {8'h03, 8'h00, 8'h11, 8'h22};
        sendStream(stim, 1'b0);
        check("mid_we_before", obsWe, 1);
        #1 reset = 1'b0;
        #1;
        check("mid_ready", obsReady, 0);
        check("mid_we", obsWe, 0);
        check("mid_addr", obsAddr, 0);
        check("mid_data", obsData, 0);
        check("mid_hold", obsHold, 0);
        check("mid_done", obsDone, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clearLog();
        startLoad();
        stim = {8'h01, 8'h00, 8'hEF, 8'hBE};
        sendStream(stim, 1'b0);
        repeat (3) @(negedge clk);
        expAddr = {0};
        expData = {32'hBEEF};
        expectWrites("after_rst");

        // A load pulse in DATA_LO must not restart the sequence.
        clearLog();
        startLoad();
        stim = {8'h03, 8'h00};
        sendStream(stim, 1'b0);
        startLoad();
        stim = {8'h01, 8'hA1, 8'h02, 8'hA2, 8'h03, 8'hA3};
        sendStream(stim, 1'b0);
        repeat (3) @(negedge clk);
        expAddr = {0, 1, 2};
        expData = {32'hA101, 32'hA202, 32'hA303};
        expectWrites("ign_load");
        check("ign_done_count", doneCyc.size(), 1);
        check("ign_hold_idle", obsHold, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
